// File: rtl/nibble_serial_add_sched_pkg.sv
// Shared types and constants for the nibble-serial add/subtract scheduler.
package nibble_serial_add_sched_pkg;

    localparam int NIBBLE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef logic req_id_t;

    function automatic logic carry_next(input logic g, input logic p, input logic cin);
        return g | (p & cin);
    endfunction

endpackage

// File: rtl/nibble_serial_add_sched_cla4_slice.sv
// 4-bit carry-lookahead slice: nibble sum plus group propagate/generate.
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       p,
    output logic       g
);

    logic [3:0] gi_s;
    logic [3:0] pi_s;
    logic [3:0] c_s;

    // Lookahead carries are expanded so no ripple path exists inside the slice
    always_comb begin
        gi_s   = a & b;
        pi_s   = a ^ b;
        c_s[0] = cin;
        c_s[1] = gi_s[0] | (pi_s[0] & cin);
        c_s[2] = gi_s[1] | (pi_s[1] & gi_s[0]) | (pi_s[1] & pi_s[0] & cin);
        c_s[3] = gi_s[2] | (pi_s[2] & gi_s[1]) | (pi_s[2] & pi_s[1] & gi_s[0])
               | (pi_s[2] & pi_s[1] & pi_s[0] & cin);
        sum    = pi_s ^ c_s;
        p      = &pi_s;
        g      = gi_s[3] | (pi_s[3] & gi_s[2]) | (pi_s[3] & pi_s[2] & gi_s[1])
               | (pi_s[3] & pi_s[2] & pi_s[1] & gi_s[0]);
    end

endmodule

// File: rtl/nibble_serial_add_sched.sv
// Two-requester add/subtract unit: round-robin grant, one nibble per cycle
// through a shared CLA slice, then a held response until the consumer takes it.
module nibble_serial_add_sched
    import nibble_serial_add_sched_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req0_sub,
    input  logic             req1_sub,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_ovf,
    output logic             rsp_zero
);

    localparam int NIB_CNT = WIDTH / NIBBLE;
    localparam int IDX_W   = $clog2(NIB_CNT);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB_CNT - 1);

    state_t            state_r, state_nx_s;
    logic [WIDTH-1:0]  a_r, b_r, sum_r, sum_nx_s;
    logic [WIDTH-1:0]  sel_a_s, sel_b_s;
    logic              sel_sub_s;
    logic [IDX_W-1:0]  idx_r;
    logic              carry_r, nib_cout_s;
    req_id_t           id_r, last_gnt_r, gnt_s;
    logic              accept_s;
    logic              rsp_valid_r, cout_r, ovf_r, zero_r;
    logic [3:0]        nib_sum_s;
    logic              grp_p_s, grp_g_s;

    cla4_slice u_cla4_slice (
        .a   (a_r[NIBBLE-1:0]),
        .b   (b_r[NIBBLE-1:0]),
        .cin (carry_r),
        .sum (nib_sum_s),
        .p   (grp_p_s),
        .g   (grp_g_s)
    );

    // Arbitration, ready generation and next-state selection
    always_comb begin
        state_nx_s = state_r;
        accept_s   = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt_s = ~last_gnt_r;
        end else if (req1_valid) begin
            gnt_s = 1'b1;
        end else begin
            gnt_s = 1'b0;
        end
        case (state_r)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    accept_s   = 1'b1;
                    req0_ready = ~gnt_s;
                    req1_ready = gnt_s;
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                if (idx_r == IDX_LAST) begin
                    state_nx_s = RESP;
                end else begin
                    state_nx_s = RUN;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = RESP;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // Operand select for the granted requester and next shifted sum
    always_comb begin
        sel_a_s    = gnt_s ? req1_a   : req0_a;
        sel_b_s    = gnt_s ? req1_b   : req0_b;
        sel_sub_s  = gnt_s ? req1_sub : req0_sub;
        nib_cout_s = carry_next(grp_g_s, grp_p_s, carry_r);
        sum_nx_s   = {nib_sum_s, sum_r[WIDTH-1:NIBBLE]};
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Datapath: operands shift right one nibble per RUN cycle, sum fills from the top
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r         <= '0;
            b_r         <= '0;
            sum_r       <= '0;
            idx_r       <= '0;
            carry_r     <= 1'b0;
            id_r        <= 1'b0;
            last_gnt_r  <= 1'b1;
            rsp_valid_r <= 1'b0;
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            zero_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_r        <= sel_a_s;
                        b_r        <= sel_b_s ^ {WIDTH{sel_sub_s}};
                        carry_r    <= sel_sub_s;
                        id_r       <= gnt_s;
                        last_gnt_r <= gnt_s;
                        idx_r      <= '0;
                    end
                end
                RUN: begin
                    a_r     <= {{NIBBLE{1'b0}}, a_r[WIDTH-1:NIBBLE]};
                    b_r     <= {{NIBBLE{1'b0}}, b_r[WIDTH-1:NIBBLE]};
                    sum_r   <= sum_nx_s;
                    carry_r <= nib_cout_s;
                    idx_r   <= idx_r + IDX_W'(1);
                    if (idx_r == IDX_LAST) begin
                        rsp_valid_r <= 1'b1;
                        cout_r      <= nib_cout_s;
                        // Carry into the MSB is recovered from the MSB sum bit
                        ovf_r       <= nib_cout_s ^ (a_r[NIBBLE-1] ^ b_r[NIBBLE-1] ^ nib_sum_s[NIBBLE-1]);
                        zero_r      <= ~|sum_nx_s;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = id_r;
    assign rsp_sum   = sum_r;
    assign rsp_cout  = cout_r;
    assign rsp_ovf   = ovf_r;
    assign rsp_zero  = zero_r;

endmodule

// File: tb/tb_nibble_serial_add_sched.sv
// Self-checking bench for nibble_serial_add_sched (WIDTH=16): vector table,
// arbitration sequence, response stall, and reset in the middle of an operation.
module tb_nibble_serial_add_sched;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         req0_sub, req1_sub;
    logic         rsp_valid, rsp_ready, rsp_id;
    logic [W-1:0] rsp_sum;
    logic         rsp_cout, rsp_ovf, rsp_zero;

    nibble_serial_add_sched #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_sub(req0_sub), .req1_sub(req1_sub),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf), .rsp_zero(rsp_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit           sub;
        logic [W-1:0] sum;
        bit           cout;
        bit           ovf;
        bit           zero;
    } vec_t;

    typedef struct {
        bit           id;
        logic [W-1:0] sum;
        bit           cout;
        bit           ovf;
        bit           zero;
    } exp_t;

    exp_t sbq[$];
    vec_t tbl[10];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    function automatic vec_t mkv(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input bit sub, input logic [W-1:0] sum,
                                 input bit cout, input bit ovf, input bit zero);
        vec_t v;
        v.id = id; v.a = a; v.b = b; v.sub = sub;
        v.sum = sum; v.cout = cout; v.ovf = ovf; v.zero = zero;
        return v;
    endfunction

    function automatic exp_t mk_exp(input vec_t v);
        exp_t e;
        e.id = v.id; e.sum = v.sum; e.cout = v.cout; e.ovf = v.ovf; e.zero = v.zero;
        return e;
    endfunction

    task automatic drive(input vec_t v, input bit en);
        if (v.id) begin
            req1_valid = en; req1_a = v.a; req1_b = v.b; req1_sub = v.sub;
        end else begin
            req0_valid = en; req0_a = v.a; req0_b = v.b; req0_sub = v.sub;
        end
    endtask

    // Present a request and wait (bounded) for its ready; returns on the acceptance edge + 1
    task automatic issue(input vec_t v, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        drive(v, 1'b1);
        for (int c = 0; c < 20; c++) begin
            #1;
            if ((v.id ? req1_ready : req0_ready) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            timeout_fail("accept");
        end else begin
            check("other_ready_low", v.id ? req0_ready : req1_ready, 32'd0);
            sbq.push_back(mk_exp(v));
            @(posedge clk);
        end
        #1;
        drive(v, 1'b0);
    endtask

    // Wait for the response, optionally stall it, compare against the scoreboard, handshake
    task automatic collect(input int stall);
        exp_t e;
        int   lat;
        bit   seen;
        seen = 1'b0;
        for (lat = 1; lat <= 20; lat++) begin
            @(negedge clk);
            #1;
            if (rsp_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen || sbq.size() == 0) begin
            timeout_fail("rsp_valid");
            if (sbq.size() != 0) void'(sbq.pop_front());
            return;
        end
        check("latency", lat, 32'd5);
        e = sbq.pop_front();
        for (int s = 0; s < stall; s++) begin
            check("stall_valid", rsp_valid, 32'd1);
            check("stall_sum", rsp_sum, e.sum);
            check("stall_flags", {rsp_id, rsp_cout, rsp_ovf, rsp_zero},
                  {e.id, e.cout, e.ovf, e.zero});
            check("stall_no_ready", {req0_ready, req1_ready}, 32'd0);
            @(negedge clk);
            #1;
        end
        check("rsp_id", rsp_id, e.id);
        check("rsp_sum", rsp_sum, e.sum);
        check("rsp_cout", rsp_cout, e.cout);
        check("rsp_ovf", rsp_ovf, e.ovf);
        check("rsp_zero", rsp_zero, e.zero);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        vec_t va0, va1, vs, vp, vr;
        exp_t e;
        bit   ok;
        bit   any;
        int   g, popped, last_c;
        bit   done;

        tbl[0] = mkv(1'b0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);
        tbl[1] = mkv(1'b1, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        tbl[2] = mkv(1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        tbl[3] = mkv(1'b0, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        tbl[4] = mkv(1'b1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        tbl[5] = mkv(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        tbl[6] = mkv(1'b1, 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        tbl[7] = mkv(1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        tbl[8] = mkv(1'b0, 16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        tbl[9] = mkv(1'b1, 16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);

        rst_n = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {rsp_valid, rsp_id, rsp_cout, rsp_ovf, rsp_zero, rsp_sum}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("idle_no_ready", {req0_ready, req1_ready, rsp_valid}, 32'd0);

        // Both requesters contend from reset: expect grants 0,1,0 six cycles apart
        va0 = mkv(1'b0, 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0);
        va1 = mkv(1'b1, 16'h0010, 16'h0001, 1'b1, 16'h000F, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        drive(va0, 1'b1);
        drive(va1, 1'b1);
        rsp_ready = 1'b1;
        g = 0; popped = 0; last_c = 0; done = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (c > 0) @(negedge clk);
            if (g == 3) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            #1;
            if (req0_ready || req1_ready) begin
                check("arb_one_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
                check("arb_id", req1_ready, g % 2);
                if (g > 0) check("arb_gap", c - last_c, 32'd6);
                sbq.push_back(mk_exp(req1_ready ? va1 : va0));
                last_c = c;
                g++;
            end
            if (rsp_valid && sbq.size() != 0) begin
                e = sbq.pop_front();
                check("arb_rsp_id", rsp_id, e.id);
                check("arb_rsp_sum", rsp_sum, e.sum);
                check("arb_rsp_cout", rsp_cout, e.cout);
                popped++;
            end
            if (g == 3 && popped == 3) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) timeout_fail("arb_sequence");
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        sbq.delete();

        for (int i = 0; i < 10; i++) begin
            issue(tbl[i], ok);
            if (ok) collect(0);
        end

        // Response held for 3 cycles with req1 pending; req1 granted right after handshake
        vs = tbl[0];
        vp = mkv(1'b1, 16'h00F0, 16'h0F0F, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0);
        issue(vs, ok);
        if (ok) begin
            drive(vp, 1'b1);
            collect(3);
            check("grant_after_handshake", req1_ready, 32'd1);
            issue(vp, ok);
            if (ok) collect(0);
        end

        // Reset on the second RUN cycle discards the operation
        vr = mkv(1'b0, 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0);
        issue(vr, ok);
        if (ok) begin
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b0;
            #1;
            check("midrun_reset_outputs",
                  {rsp_valid, rsp_id, rsp_cout, rsp_ovf, rsp_zero, rsp_sum}, 32'd0);
            sbq.delete();
            @(negedge clk);
            rst_n = 1'b1;
            any = 1'b0;
            repeat (8) begin
                @(negedge clk);
                #1;
                any = any | rsp_valid;
            end
            check("no_rsp_after_reset", any, 32'd0);
        end
        vr = mkv(1'b1, 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0);
        issue(vr, ok);
        if (ok) collect(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
